// File: rtl/i3c_bus_monitor.sv
// I3C/I2C bus monitor: deglitches synchronized SCL/SDA, derives edge and
// START/repeated-START/STOP strobes, and tracks FREE/IDLE/BUSY bus state.
module i3c_bus_monitor #(
  parameter int FiltW    = 4,
  parameter int IdleCntW = 20
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                scl_i,
  input  logic                sda_i,
  input  logic [FiltW-1:0]    filt_cycles_i,
  input  logic [IdleCntW-1:0] t_idle_i,
  output logic                scl_o,
  output logic                sda_o,
  output logic                scl_posedge_o,
  output logic                scl_negedge_o,
  output logic                start_det_o,
  output logic                rstart_det_o,
  output logic                stop_det_o,
  output logic                bus_busy_o,
  output logic                bus_idle_o
);

  typedef enum logic [1:0] {
    BUS_FREE,
    BUS_IDLE,
    BUS_BUSY
  } bus_state_e;

  // Bit 1 carries SCL, bit 0 carries SDA throughout.
  logic [1:0]            raw;
  logic [1:0]            stable_q;
  logic [1:0]            prev_q;
  logic [1:0][FiltW-1:0] filt_cnt_q;

  bus_state_e            state_q, state_d;
  logic [IdleCntW-1:0]   idle_cnt_q, idle_cnt_d;

  logic                  hold_reset;
  logic                  both_high;
  logic                  start_cond;
  logic                  stop_cond;

  assign raw        = {scl_i, sda_i};
  assign hold_reset = rst_i | ~enable_i;

  // A level change is accepted only once it has persisted N+1 cycles; the
  // counter stops at N, so it cannot wrap.
  always_ff @(posedge clk_i) begin
    if (hold_reset) begin
      stable_q   <= 2'b11;
      prev_q     <= 2'b11;
      filt_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      prev_q <= stable_q;
      for (int i = 0; i < 2; i++) begin
        if (raw[i] == stable_q[i]) begin
          filt_cnt_q[i] <= '0;
        end else if (filt_cnt_q[i] >= filt_cycles_i) begin
          stable_q[i]   <= raw[i];
          filt_cnt_q[i] <= '0;
        end else begin
          filt_cnt_q[i] <= filt_cnt_q[i] + FiltW'(1);
        end
      end
    end
  end

  assign scl_o = stable_q[1];
  assign sda_o = stable_q[0];

  assign scl_posedge_o = stable_q[1] & ~prev_q[1];
  assign scl_negedge_o = ~stable_q[1] & prev_q[1];

  // SCL must be high on both sides of the SDA transition, so simultaneous
  // SCL/SDA changes never qualify.
  assign start_cond = prev_q[1] & stable_q[1] & prev_q[0] & ~stable_q[0];
  assign stop_cond  = prev_q[1] & stable_q[1] & ~prev_q[0] & stable_q[0];

  assign start_det_o  = start_cond & (state_q != BUS_BUSY);
  assign rstart_det_o = start_cond & (state_q == BUS_BUSY);
  assign stop_det_o   = stop_cond;

  assign both_high = stable_q[1] & stable_q[0];

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    state_d    = state_q;
    idle_cnt_d = '0;
    case (state_q)
      BUS_FREE: begin
        if (start_cond) begin
          state_d = BUS_BUSY;
        end else if (both_high && (idle_cnt_q >= t_idle_i)) begin
          state_d = BUS_IDLE;
        end else if (both_high) begin
          idle_cnt_d = (&idle_cnt_q) ? idle_cnt_q : idle_cnt_q + IdleCntW'(1);
        end
      end
      BUS_IDLE: begin
        if (start_cond) begin
          state_d = BUS_BUSY;
        end else if (!both_high) begin
          state_d = BUS_FREE;
        end
      end
      BUS_BUSY: begin
        if (stop_cond) begin
          state_d = BUS_FREE;
        end
      end
      default: state_d = BUS_FREE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (hold_reset) begin
      state_q    <= BUS_FREE;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign bus_busy_o = (state_q == BUS_BUSY);
  assign bus_idle_o = (state_q == BUS_IDLE);

endmodule

// File: tb/tb_i3c_bus_monitor.sv
// Self-checking bench for i3c_bus_monitor: a scoreboard of expected strobe
// events (cycle + strobe pattern) plus inline level/state checks per scenario.
module tb_i3c_bus_monitor;

  localparam int FiltW    = 4;
  localparam int IdleCntW = 20;

  // Strobe pattern bit order: {posedge, negedge, start, rstart, stop}
  localparam logic [4:0] EV_POS    = 5'b10000;
  localparam logic [4:0] EV_NEG    = 5'b01000;
  localparam logic [4:0] EV_START  = 5'b00100;
  localparam logic [4:0] EV_RSTART = 5'b00010;
  localparam logic [4:0] EV_STOP   = 5'b00001;

  typedef struct {
    int         cyc;
    logic [4:0] strobes;
  } ev_t;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b1;
  logic                enable_i = 1'b1;
  logic                scl_i = 1'b0;
  logic                sda_i = 1'b0;
  logic [FiltW-1:0]    filt_cycles_i = 4'd2;
  logic [IdleCntW-1:0] t_idle_i = 20'd10;
  logic                scl_o, sda_o, scl_posedge_o, scl_negedge_o;
  logic                start_det_o, rstart_det_o, stop_det_o;
  logic                bus_busy_o, bus_idle_o;

  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];

  logic [4:0] mon_s;
  ev_t        mon_e;

  i3c_bus_monitor #(.FiltW(FiltW), .IdleCntW(IdleCntW)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .enable_i      (enable_i),
    .scl_i         (scl_i),
    .sda_i         (sda_i),
    .filt_cycles_i (filt_cycles_i),
    .t_idle_i      (t_idle_i),
    .scl_o         (scl_o),
    .sda_o         (sda_o),
    .scl_posedge_o (scl_posedge_o),
    .scl_negedge_o (scl_negedge_o),
    .start_det_o   (start_det_o),
    .rstart_det_o  (rstart_det_o),
    .stop_det_o    (stop_det_o),
    .bus_busy_o    (bus_busy_o),
    .bus_idle_o    (bus_idle_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Scoreboard: any strobe activity must match the oldest expected event.
  always @(negedge clk_i) begin
    mon_s = {scl_posedge_o, scl_negedge_o, start_det_o, rstart_det_o, stop_det_o};
    if (mon_s != 5'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: got %b at cycle %0d, required no strobe", mon_s, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != cyc || mon_e.strobes !== mon_s) begin
          errors++;
          $display("FAIL strobe_event: got %b at cycle %0d, required %b at cycle %0d",
                   mon_s, cyc, mon_e.strobes, mon_e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_ev(input int dly, input logic [4:0] s);
    exp_q.push_back('{cyc: cyc + dly, strobes: s});
  endtask

  task automatic configure(input int n, input int t);
    enable_i = 1'b0;
    tick();
    filt_cycles_i = FiltW'(n);
    t_idle_i      = IdleCntW'(t);
    enable_i      = 1'b1;
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    rst_i = 1'b1; scl_i = 1'b0; sda_i = 1'b0;
    filt_cycles_i = 4'd2; t_idle_i = 20'd10;
    for (int i = 0; i < 3; i++) begin
      tick();
      obs = {scl_o, sda_o, scl_posedge_o, scl_negedge_o, start_det_o,
             rstart_det_o, stop_det_o, bus_busy_o, bus_idle_o};
      checks++;
      if (obs !== 9'b110000000) begin
        errors++;
        $display("FAIL reset_state: got %b, required %b", obs, 9'b110000000);
      end
    end
    rst_i = 1'b0; scl_i = 1'b1; sda_i = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      checks++;
      if (bus_idle_o !== (k == 11)) begin
        errors++;
        $display("FAIL reset_idle_time: cycle %0d after release bus_idle_o=%b, required %b",
                 k, bus_idle_o, (k == 11));
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_strobes: %0d expected strobes not seen, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_deglitch();
    configure(3, 10);
    sda_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (sda_o !== 1'b1) begin
        errors++;
        $display("FAIL deglitch_short: cycle %0d sda_o=%b, required 1", k, sda_o);
      end
    end
    sda_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (sda_o !== 1'b1) begin
        errors++;
        $display("FAIL deglitch_short_tail: cycle %0d sda_o=%b, required 1", k, sda_o);
      end
    end
    sda_i = 1'b0;
    expect_ev(4, EV_START);
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (sda_o !== (k < 4)) begin
        errors++;
        $display("FAIL deglitch_fall: cycle %0d sda_o=%b, required %b", k, sda_o, (k < 4));
      end
    end
    sda_i = 1'b1;
    expect_ev(4, EV_STOP);
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (sda_o !== (k >= 4)) begin
        errors++;
        $display("FAIL deglitch_rise: cycle %0d sda_o=%b, required %b", k, sda_o, (k >= 4));
      end
      if (k == 1 || k == 5) begin
        checks++;
        if (bus_busy_o !== (k == 1)) begin
          errors++;
          $display("FAIL deglitch_busy: cycle %0d bus_busy_o=%b, required %b", k, bus_busy_o, (k == 1));
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL deglitch_strobes: %0d expected strobes not seen, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_start_stop();
    configure(0, 4);
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if (bus_idle_o !== 1'b1) begin
      errors++;
      $display("FAIL ss_idle: bus_idle_o=%b, required 1", bus_idle_o);
    end
    sda_i = 1'b0;
    expect_ev(1, EV_START);
    tick();
    checks++;
    if ({start_det_o, bus_busy_o} !== 2'b10) begin
      errors++;
      $display("FAIL ss_start: start/busy=%b, required 10", {start_det_o, bus_busy_o});
    end
    tick();
    checks++;
    if ({start_det_o, bus_busy_o} !== 2'b01) begin
      errors++;
      $display("FAIL ss_busy: start/busy=%b, required 01", {start_det_o, bus_busy_o});
    end
    scl_i = 1'b0; expect_ev(1, EV_NEG); tick();
    sda_i = 1'b1; tick();
    scl_i = 1'b1; expect_ev(1, EV_POS); tick();
    sda_i = 1'b0; expect_ev(1, EV_RSTART); tick();
    checks++;
    if ({rstart_det_o, start_det_o} !== 2'b10) begin
      errors++;
      $display("FAIL ss_rstart: rstart/start=%b, required 10", {rstart_det_o, start_det_o});
    end
    tick();
    checks++;
    if (bus_busy_o !== 1'b1) begin
      errors++;
      $display("FAIL ss_rstart_busy: bus_busy_o=%b, required 1", bus_busy_o);
    end
    sda_i = 1'b1; expect_ev(1, EV_STOP); tick();
    checks++;
    if ({stop_det_o, bus_busy_o} !== 2'b11) begin
      errors++;
      $display("FAIL ss_stop: stop/busy=%b, required 11", {stop_det_o, bus_busy_o});
    end
    tick();
    checks++;
    if ({stop_det_o, bus_busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL ss_free: stop/busy=%b, required 00", {stop_det_o, bus_busy_o});
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL ss_strobes: %0d expected strobes not seen, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_simultaneous();
    configure(0, 1000);
    tick(); tick();
    scl_i = 1'b0; sda_i = 1'b0;
    expect_ev(1, EV_NEG);
    tick();
    checks++;
    if ({scl_negedge_o, start_det_o} !== 2'b10) begin
      errors++;
      $display("FAIL simul_fall: negedge/start=%b, required 10", {scl_negedge_o, start_det_o});
    end
    tick();
    checks++;
    if ({bus_busy_o, bus_idle_o} !== 2'b00) begin
      errors++;
      $display("FAIL simul_fall_state: busy/idle=%b, required 00", {bus_busy_o, bus_idle_o});
    end
    scl_i = 1'b1; sda_i = 1'b1;
    expect_ev(1, EV_POS);
    tick();
    checks++;
    if ({scl_posedge_o, stop_det_o} !== 2'b10) begin
      errors++;
      $display("FAIL simul_rise: posedge/stop=%b, required 10", {scl_posedge_o, stop_det_o});
    end
    tick();
    checks++;
    if ({bus_busy_o, bus_idle_o} !== 2'b00) begin
      errors++;
      $display("FAIL simul_rise_state: busy/idle=%b, required 00", {bus_busy_o, bus_idle_o});
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL simul_strobes: %0d expected strobes not seen, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_idle_abort();
    configure(1, 10);
    // SCL input low at edges 6 and 7: filtered low at edges 7..8, counter
    // restarts once both lines are back high, IDLE after 11 more edges.
    expect_ev(7, EV_NEG);
    expect_ev(9, EV_POS);
    for (int k = 1; k <= 20; k++) begin
      scl_i = (k == 6 || k == 7) ? 1'b0 : 1'b1;
      tick();
      checks++;
      if (bus_idle_o !== (k == 20)) begin
        errors++;
        $display("FAIL idle_abort: cycle %0d bus_idle_o=%b, required %b", k, bus_idle_o, (k == 20));
      end
    end
    scl_i = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL idle_abort_strobes: %0d expected strobes not seen, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_enable_drop();
    logic [4:0] obs;
    configure(0, 1000);
    tick();
    sda_i = 1'b0; expect_ev(1, EV_START);
    tick(); tick();
    checks++;
    if (bus_busy_o !== 1'b1) begin
      errors++;
      $display("FAIL en_busy: bus_busy_o=%b, required 1", bus_busy_o);
    end
    scl_i = 1'b0; expect_ev(1, EV_NEG); tick();
    enable_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      obs = {scl_o, sda_o, bus_busy_o, bus_idle_o, stop_det_o};
      checks++;
      if (obs !== 5'b11000) begin
        errors++;
        $display("FAIL en_drop: scl/sda/busy/idle/stop=%b, required 11000", obs);
      end
    end
    scl_i = 1'b1; sda_i = 1'b1; enable_i = 1'b1;
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL en_strobes: %0d expected strobes not seen, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_deglitch();
    test_start_stop();
    test_simultaneous();
    test_idle_abort();
    test_enable_drop();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
